iic_arbiter: RTL and testbench
==============================

// Module: iic_arbiter
// PURPOSE
// - Shares one IIC register-access master (iic_start/iic_busy/reg_rw/reg_addr/send_data/recv_data)
//   between NUM_REQ requesters, e.g. EEPROM test sequencer and sensor-config sequencer.
// - Round-robin grant; one transaction in flight; per-transaction timeout.
// - Enforces a post-transaction hold-off so EEPROM internal write cycles complete before the next access.
// PARAMETERS
// - NUM_REQ            2     number of requesters (2..8)
// - CLK_FRE            50    clock frequency, MHz
// - IIC_SLAVE_REG_EX   1     extra register-address bytes; REG_W = 8 + 8*IIC_SLAVE_REG_EX
// - TIMEOUT_US         1000  max start-to-done time per transaction, us
// - GAP_US             5000  idle hold-off after every completed write, us (reads: 0)
// PORTS
// - clk        in   1              system clock
// - rst        in   1              synchronous, active-high reset
// - req_valid  in   NUM_REQ        request pending, held until req_ack
// - req_rw     in   NUM_REQ        1=read, 0=write
// - req_addr   in   NUM_REQ*REG_W  register address, slice i
// - req_wdata  in   NUM_REQ*8      write data, slice i
// - req_ack    out  NUM_REQ        1-cycle pulse: request i captured
// - rsp_valid  out  NUM_REQ        1-cycle pulse: transaction i finished
// - rsp_err    out  1              valid with rsp_valid: 1=timeout
// - rsp_rdata  out  8              valid with rsp_valid: read data (0 on write/err)
// - iic_start  out  1              to master: start request, held until iic_busy seen
// - iic_busy   in   1              from master: transaction in progress
// - reg_rw     out  1              to master
// - reg_addr   out  REG_W          to master
// - send_data  out  8              to master
// - recv_data  in   8              from master, valid at iic_busy falling edge
// BEHAVIOUR
// - Reset (rst=1 at clk edge): state=IDLE, all outputs 0, rr pointer=0, counters=0. Reset mid-transaction
//   drops iic_start immediately; no rsp_valid issued for the aborted transaction.
// - busy_r = iic_busy delayed 1 cycle; done = !iic_busy & busy_r.
// - IDLE: if any req_valid and !iic_busy: pick winner by round-robin starting at (last_grant+1) mod NUM_REQ;
//   same cycle pulse req_ack[w], register rw/addr/wdata onto reg_rw/reg_addr/send_data, assert iic_start,
//   clear timer, -> ISSUE. If iic_busy=1 in IDLE, no grant.
// - ISSUE: iic_start=1 until iic_busy=1 sampled; then iic_start=0 next cycle, -> BUSY.
// - BUSY: on done: capture recv_data (reads) into rsp_rdata, rsp_err=0, -> RESP.
// - Timer counts every cycle in ISSUE and BUSY; at CLK_FRE*TIMEOUT_US: iic_start=0, rsp_err=1,
//   rsp_rdata=0, -> RESP. Timeout and done in same cycle: done wins.
// - RESP: rsp_valid[w]=1 for exactly 1 cycle; last_grant=w; -> HOLD if write (or err), else IDLE.
// - HOLD: count CLK_FRE*GAP_US cycles, then -> IDLE. No grants during HOLD.
// - reg_rw/reg_addr/send_data stable from grant until next grant.
// - Latency: req_valid (IDLE, bus free) -> req_ack same-cycle registered (1 clk); done -> rsp_valid 1 clk.
// - A requester must not expect a new req_ack before its rsp_valid; req_valid held through that window
//   counts as a fresh request only after rsp_valid.
// - Widths: timer 32 bit, saturating; pointer $clog2(NUM_REQ) bits, wraps NUM_REQ-1 -> 0.
// STRUCTURE
// - iic_arb_pkg: state enum {IDLE,ISSUE,BUSY,RESP,HOLD}, function reg_w(IIC_SLAVE_REG_EX),
//   function us2cyc(CLK_FRE,us).
// - Sub-module rr_arbiter (NUM_REQ): req vector + pointer -> one-hot grant + index; combinational pick,
//   pointer update driven by iic_arbiter.
// - Top: FSM, timer, busy edge detect, capture registers.
// TESTING (use CLK_FRE=1, TIMEOUT_US=100, GAP_US=20 for short sims; master BFM asserts busy 3 clk after
//   start, holds 10 clk)
// - Single write: req0 addr=0x0001 wdata=0x5A -> req_ack[0] pulse, reg_addr=0x0001, send_data=0x5A,
//   one iic_start episode, rsp_valid[0] with rsp_err=0, then 20 idle clk before any new grant.
// - Single read: req1 rw=1 addr=0x0001, BFM recv_data=0xA5 -> rsp_valid[1], rsp_rdata=0xA5, no HOLD.
// - Contention: req0 and req1 both held -> grants alternate 0,1,0,1 over 4 transactions.
// - Timeout: BFM never asserts busy -> iic_start drops after 100 clk, rsp_err=1, rsp_rdata=0,
//   then HOLD 20 clk.
// - Busy at idle: iic_busy=1 externally while req0 valid -> no req_ack until busy drops.
// - Reset mid-BUSY: rst=1 for 1 clk -> iic_start=0, rsp_valid never pulses, next req served normally.

Source files
------------

// File: rtl/iic_arb_pkg.sv
// Shared definitions for the IIC register-access arbiter: FSM states and
// helpers that size the register-address bus and convert microseconds to cycles.
package iic_arb_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        BUSY,
        RESP,
        HOLD
    } arb_state_e;

    function automatic int reg_w(input int reg_ex);
        return DATA_W + DATA_W * reg_ex;
    endfunction

    function automatic logic [31:0] us2cyc(input int clk_fre, input int us);
        return 32'(clk_fre * us);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request strictly after ptr, wrapping.
// Purely combinational; the owner of ptr decides when it advances.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               hit
);

    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % NUM_REQ);
            if (!hit && req[cand]) begin
                hit         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iic_arbiter.sv
// Shares one IIC register-access master between NUM_REQ requesters with
// round-robin grant, per-transaction timeout and a post-write hold-off.
//
// state | meaning
// IDLE  | waiting for a request while the master is not busy
// ISSUE | iic_start raised, waiting for the master to report busy
// BUSY  | master working, waiting for the busy falling edge
// RESP  | rsp_valid pulse for the granted requester
// HOLD  | hold-off after a write or timeout, no grants
module iic_arbiter
    import iic_arb_pkg::*;
#(
    parameter  int NUM_REQ          = 2,
    parameter  int CLK_FRE          = 50,
    parameter  int IIC_SLAVE_REG_EX = 1,
    parameter  int TIMEOUT_US       = 1000,
    parameter  int GAP_US           = 5000,
    localparam int REG_W            = reg_w(IIC_SLAVE_REG_EX)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_rw,
    input  logic [NUM_REQ*REG_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic                       rsp_err,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       iic_start,
    input  logic                       iic_busy,
    output logic                       reg_rw,
    output logic [REG_W-1:0]           reg_addr,
    output logic [DATA_W-1:0]          send_data,
    input  logic [DATA_W-1:0]          recv_data
);

    localparam int          IW      = $clog2(NUM_REQ);
    localparam logic [31:0] TO_CYC  = us2cyc(CLK_FRE, TIMEOUT_US);
    localparam logic [31:0] GAP_CYC = us2cyc(CLK_FRE, GAP_US);

    arb_state_e          state;
    logic                busy_r;
    logic                done;
    logic [31:0]         timer;
    logic [31:0]         timer_next;
    logic                timer_exp;
    logic [31:0]         gap_cnt;
    logic [IW-1:0]       last_grant;
    logic [IW-1:0]       cur_idx;
    logic [NUM_REQ-1:0]  cur_mask;
    logic [NUM_REQ-1:0]  grant;
    logic [IW-1:0]       grant_idx;
    logic                grant_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req   (req_valid),
        .ptr   (last_grant),
        .grant (grant),
        .idx   (grant_idx),
        .hit   (grant_hit)
    );

    assign done       = !iic_busy && busy_r;
    assign timer_next = (timer == 32'hFFFF_FFFF) ? timer : timer + 32'd1;
    assign timer_exp  = (timer_next >= TO_CYC);
    assign cur_mask   = {{(NUM_REQ-1){1'b0}}, 1'b1} << cur_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy_r     <= 1'b0;
            timer      <= '0;
            gap_cnt    <= '0;
            last_grant <= '0;
            cur_idx    <= '0;
            req_ack    <= '0;
            rsp_valid  <= '0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            iic_start  <= 1'b0;
            reg_rw     <= 1'b0;
            reg_addr   <= '0;
            send_data  <= '0;
        end else begin
            busy_r    <= iic_busy;
            req_ack   <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (grant_hit && !iic_busy) begin
                        req_ack   <= grant;
                        cur_idx   <= grant_idx;
                        reg_rw    <= req_rw[grant_idx];
                        reg_addr  <= req_addr[grant_idx*REG_W +: REG_W];
                        send_data <= req_wdata[grant_idx*DATA_W +: DATA_W];
                        iic_start <= 1'b1;
                        timer     <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= timer_next;
                    if (timer_exp) begin
                        iic_start <= 1'b0;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_valid <= cur_mask;
                        state     <= RESP;
                    end else if (iic_busy) begin
                        iic_start <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    timer <= timer_next;
                    // A completion seen on the expiry cycle still counts as success.
                    if (done) begin
                        rsp_err   <= 1'b0;
                        rsp_rdata <= reg_rw ? recv_data : '0;
                        rsp_valid <= cur_mask;
                        state     <= RESP;
                    end else if (timer_exp) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_valid <= cur_mask;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    last_grant <= cur_idx;
                    if ((!reg_rw || rsp_err) && (GAP_CYC != 32'd0)) begin
                        gap_cnt <= '0;
                        state   <= HOLD;
                    end else begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    gap_cnt <= gap_cnt + 32'd1;
                    if (gap_cnt + 32'd1 >= GAP_CYC) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iic_arbiter.sv
// Bench for iic_arbiter: timestamp-based reference model checked every cycle,
// a simple IIC master model, and directed scenarios with literal expectations.
module tb_iic_arbiter;

    localparam int NUM_REQ = 2;
    localparam int REG_W   = 16;
    localparam int TMO     = 100;
    localparam int GAP     = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_rw = '0;
    logic [31:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_ack;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [7:0]  rsp_rdata;
    logic        iic_start;
    logic        iic_busy;
    logic        reg_rw;
    logic [15:0] reg_addr;
    logic [7:0]  send_data;
    logic [7:0]  recv_data;

    logic        bfm_busy = 1'b0;
    logic        ext_busy = 1'b0;
    bit          bfm_en = 1'b1;
    logic [7:0]  bfm_rdata = '0;

    int checks = 0;
    int errors = 0;
    int n = 0;

    assign iic_busy  = bfm_busy | ext_busy;
    assign recv_data = bfm_rdata;

    always #5 clk = ~clk;

    iic_arbiter #(
        .NUM_REQ          (NUM_REQ),
        .CLK_FRE          (1),
        .IIC_SLAVE_REG_EX (1),
        .TIMEOUT_US       (TMO),
        .GAP_US           (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .iic_start (iic_start),
        .iic_busy  (iic_busy),
        .reg_rw    (reg_rw),
        .reg_addr  (reg_addr),
        .send_data (send_data),
        .recv_data (recv_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is either in flight (with its grant time)
    // or the arbiter is free to grant from cycle m_free_at onwards.
    bit          m_txn = 1'b0;
    bit          m_busy_seen = 1'b0;
    bit          m_prev_busy = 1'b0;
    int          m_w = 0;
    int          m_t0 = 0;
    int          m_last = 0;
    int          m_free_at = 0;
    logic [1:0]  e_ack = '0;
    logic [1:0]  e_rsp = '0;
    logic        e_start = 1'b0;
    logic        e_rw = 1'b0;
    logic [15:0] e_addr = '0;
    logic [7:0]  e_wdata = '0;
    logic        e_err = 1'b0;
    logic [7:0]  e_rdata = '0;

    task automatic model_finish(input logic err, input logic [7:0] rd);
        e_rsp[m_w] = 1'b1;
        e_err      = err;
        e_rdata    = rd;
        e_start    = 1'b0;
        m_txn      = 1'b0;
        m_last     = m_w;
        m_free_at  = n + 2 + ((!e_rw || err) ? GAP : 0);
    endtask

    always @(posedge clk) begin
        int w;
        int c;
        n++;
        e_ack = '0;
        e_rsp = '0;
        if (rst) begin
            m_txn = 1'b0; m_last = 0; m_free_at = 0; m_prev_busy = 1'b0;
            e_start = 1'b0; e_rw = 1'b0; e_addr = '0; e_wdata = '0;
            e_err = 1'b0; e_rdata = '0;
        end else begin
            if (m_txn) begin
                if (m_busy_seen && m_prev_busy && !iic_busy)
                    model_finish(1'b0, e_rw ? recv_data : 8'h00);
                else if (n - m_t0 >= TMO)
                    model_finish(1'b1, 8'h00);
                else if (!m_busy_seen && iic_busy) begin
                    m_busy_seen = 1'b1;
                    e_start     = 1'b0;
                end
            end else if (n >= m_free_at && req_valid != 2'b00 && !iic_busy) begin
                w = -1;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    c = (m_last + k) % NUM_REQ;
                    if (w < 0 && req_valid[c]) w = c;
                end
                m_w         = w;
                m_t0        = n;
                m_txn       = 1'b1;
                m_busy_seen = 1'b0;
                e_ack[w]    = 1'b1;
                e_start     = 1'b1;
                e_rw        = req_rw[w];
                e_addr      = req_addr[w*REG_W +: REG_W];
                e_wdata     = req_wdata[w*8 +: 8];
            end
            m_prev_busy = iic_busy;
        end
    end

    always @(negedge clk) begin
        if (n >= 1) begin
            chk("req_ack", 32'(req_ack), 32'(e_ack));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
            chk("iic_start", 32'(iic_start), 32'(e_start));
            chk("reg_rw", 32'(reg_rw), 32'(e_rw));
            chk("reg_addr", 32'(reg_addr), 32'(e_addr));
            chk("send_data", 32'(send_data), 32'(e_wdata));
            if (e_rsp != 2'b00) begin
                chk("rsp_err", 32'(rsp_err), 32'(e_err));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
            end
        end
    end

    int   start_rises = 0;
    int   start_high = 0;
    int   rsp_pulses = 0;
    int   ack_pulses = 0;
    logic start_prev = 1'b0;

    always @(negedge clk) begin
        if (n >= 1) begin
            if (iic_start === 1'b1 && start_prev !== 1'b1) start_rises++;
            if (iic_start === 1'b1) start_high++;
            if (rsp_valid !== 2'b00) rsp_pulses++;
            if (req_ack !== 2'b00) ack_pulses++;
            start_prev = iic_start;
        end
    end

    // Master model: busy rises 3 clk after it sees iic_start, stays 10 clk.
    initial begin
        forever begin
            @(posedge clk);
            if (bfm_en && iic_start === 1'b1) begin
                repeat (2) @(posedge clk);
                #1 bfm_busy = 1'b1;
                repeat (10) @(posedge clk);
                #1 bfm_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic rw, input logic [15:0] a, input logic [7:0] d);
        req_rw[i]             = rw;
        req_addr[i*16 +: 16]  = a;
        req_wdata[i*8 +: 8]   = d;
        req_valid[i]          = 1'b1;
    endtask

    task automatic wait_ack(input int idx, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget && at < 0; k++) begin
            tick();
            if (req_ack[idx] === 1'b1) begin
                at = n;
                req_valid[idx] = 1'b0;
            end
        end
        if (at < 0) begin
            checks++; errors++;
            $display("FAIL ack_wait req%0d: no req_ack within %0d cycles", idx, budget);
        end
    endtask

    task automatic wait_any_ack(input int budget, output int who);
        who = -1;
        for (int k = 0; k < budget && who < 0; k++) begin
            tick();
            if (req_ack === 2'b01) who = 0;
            else if (req_ack === 2'b10) who = 1;
        end
        if (who < 0) begin
            checks++; errors++;
            $display("FAIL contention_wait: no single req_ack within %0d cycles", budget);
        end
    endtask

    task automatic wait_rsp(input int idx, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget && at < 0; k++) begin
            tick();
            if (rsp_valid[idx] === 1'b1) at = n;
        end
        if (at < 0) begin
            checks++; errors++;
            $display("FAIL rsp_wait req%0d: no rsp_valid within %0d cycles", idx, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t_ack;
        int t_rsp;
        int t_ref;
        int s0;
        int who;
        int order [4];

        repeat (3) tick();
        rst = 1'b0;
        chk("reset req_ack", 32'(req_ack), 32'h0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset iic_start", 32'(iic_start), 32'h0);
        chk("reset reg_addr", 32'(reg_addr), 32'h0);
        chk("reset rsp_rdata", 32'(rsp_rdata), 32'h0);
        tick();

        // Single write from requester 0.
        s0 = start_rises;
        t_ref = n;
        set_req(0, 1'b0, 16'h0001, 8'h5A);
        wait_ack(0, 10, t_ack);
        chk("write ack latency", 32'(t_ack - t_ref), 32'd1);
        chk("write reg_addr", 32'(reg_addr), 32'h0001);
        chk("write send_data", 32'(send_data), 32'h5A);
        chk("write reg_rw", 32'(reg_rw), 32'h0);
        wait_rsp(0, 150, t_rsp);
        chk("write rsp_err", 32'(rsp_err), 32'h0);
        chk("write start episodes", 32'(start_rises - s0), 32'd1);

        // Single read from requester 1, queued right after the write.
        bfm_rdata = 8'hA5;
        set_req(1, 1'b1, 16'h0001, 8'h00);
        wait_ack(1, 40, t_ack);
        chk("write hold-off", 32'(t_ack - t_rsp), 32'd22);
        chk("read reg_rw", 32'(reg_rw), 32'h1);
        wait_rsp(1, 150, t_rsp);
        chk("read rsp_rdata", 32'(rsp_rdata), 32'hA5);
        chk("read rsp_err", 32'(rsp_err), 32'h0);

        set_req(1, 1'b0, 16'h0102, 8'h33);
        wait_ack(1, 40, t_ack);
        chk("read no hold-off", 32'(t_ack - t_rsp), 32'd2);
        chk("write2 reg_addr", 32'(reg_addr), 32'h0102);
        wait_rsp(1, 150, t_rsp);

        // Contention: both requesters held for four transactions.
        bfm_rdata = 8'h77;
        set_req(0, 1'b0, 16'h0010, 8'h11);
        set_req(1, 1'b1, 16'h0020, 8'h00);
        for (int k = 0; k < 4; k++) begin
            wait_any_ack(80, who);
            order[k] = who;
        end
        req_valid = 2'b00;
        chk("rr grant 0", 32'(order[0]), 32'd0);
        chk("rr grant 1", 32'(order[1]), 32'd1);
        chk("rr grant 2", 32'(order[2]), 32'd0);
        chk("rr grant 3", 32'(order[3]), 32'd1);
        wait_rsp(1, 150, t_rsp);
        chk("contention read rdata", 32'(rsp_rdata), 32'h77);

        // Timeout: master never answers.
        bfm_en = 1'b0;
        bfm_rdata = 8'hEE;
        s0 = start_high;
        set_req(0, 1'b1, 16'h00FF, 8'h00);
        wait_ack(0, 10, t_ack);
        wait_rsp(0, 150, t_rsp);
        chk("timeout start cycles", 32'(start_high - s0), 32'd100);
        chk("timeout rsp latency", 32'(t_rsp - t_ack), 32'd100);
        chk("timeout rsp_err", 32'(rsp_err), 32'h1);
        chk("timeout rsp_rdata", 32'(rsp_rdata), 32'h0);
        bfm_en = 1'b1;
        set_req(1, 1'b0, 16'h00AB, 8'hC3);
        wait_ack(1, 40, t_ack);
        chk("timeout hold-off", 32'(t_ack - t_rsp), 32'd22);
        wait_rsp(1, 150, t_rsp);

        // Master busy while idle: no grant until busy drops.
        ext_busy = 1'b1;
        s0 = ack_pulses;
        set_req(0, 1'b0, 16'h0033, 8'h44);
        repeat (30) tick();
        chk("busy-at-idle no grant", 32'(ack_pulses - s0), 32'd0);
        ext_busy = 1'b0;
        t_ref = n;
        wait_ack(0, 5, t_ack);
        chk("grant after busy drop", 32'(t_ack - t_ref), 32'd1);
        wait_rsp(0, 150, t_rsp);

        // Reset in the middle of a busy transaction.
        set_req(1, 1'b0, 16'h0077, 8'h88);
        wait_ack(1, 40, t_ack);
        t_ref = -1;
        for (int k = 0; k < 20 && t_ref < 0; k++) begin
            tick();
            if (iic_busy === 1'b1) t_ref = n;
        end
        if (t_ref < 0) begin
            checks++; errors++;
            $display("FAIL busy_wait: master never went busy");
        end
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid-reset iic_start", 32'(iic_start), 32'h0);
        chk("mid-reset reg_addr", 32'(reg_addr), 32'h0);
        chk("mid-reset send_data", 32'(send_data), 32'h0);
        s0 = rsp_pulses;
        repeat (30) tick();
        chk("mid-reset no rsp", 32'(rsp_pulses - s0), 32'd0);
        bfm_rdata = 8'h3C;
        set_req(0, 1'b1, 16'h0005, 8'h00);
        wait_ack(0, 40, t_ack);
        wait_rsp(0, 150, t_rsp);
        chk("post-reset read rdata", 32'(rsp_rdata), 32'h3C);
        chk("post-reset read err", 32'(rsp_err), 32'h0);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
